// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM states,
// default datapath width and small opcode helpers.
package alu_pkg;

  // Default datapath width
  localparam int unsigned ALU_W = 8;

  // Opcode width (also the width of the s2:s0 select bundle)
  localparam int unsigned OP_W = 3;

  // Operation codes; the value doubles as the result-mux select
  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b010;
  localparam logic [OP_W-1:0] OP_OR   = 3'b011;
  localparam logic [OP_W-1:0] OP_SLL  = 3'b100;
  localparam logic [OP_W-1:0] OP_SRA  = 3'b101;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b110;
  localparam logic [OP_W-1:0] OP_PASS = 3'b111;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_SELECT = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  // True for the two opcodes that run through the iterative shifter
  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_SRA);
  endfunction

  // True for the sign-extending (arithmetic) shift
  function automatic logic is_arith_shift(input logic [OP_W-1:0] op);
    return op == OP_SRA;
  endfunction

endpackage

// File: rtl/alu_shift_reg.sv
// Iterative one-bit-per-cycle shifter with its down-counter.
// load captures the operand and shift amount; step shifts once and
// decrements; last_c flags the final step so the FSM can leave SHIFT.
module alu_shift_reg
  import alu_pkg::*;
#(
  parameter int unsigned W  = ALU_W,
  parameter int unsigned SW = $clog2(W)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic          arith,
  input  logic [W-1:0]  load_val,
  input  logic [SW-1:0] load_cnt,
  output logic [W-1:0]  shift_q,
  output logic          last_c
);

  logic [SW-1:0] cnt;

  // Shift register and remaining-step counter
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q <= '0;
      cnt     <= '0;
    end else if (load) begin
      shift_q <= load_val;
      cnt     <= load_cnt;
    end else if (step) begin
      if (arith) begin
        shift_q <= {shift_q[W-1], shift_q[W-1:1]};
      end else begin
        shift_q <= {shift_q[W-2:0], 1'b0};
      end
      cnt <= cnt - SW'(1);
    end
  end

  // Final step is the one taken while the counter reads one
  assign last_c = (cnt == SW'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Control and operand stage in front of the 8-way ALU result mux bank.
// Accepts one request at a time, latches operands, runs multi-cycle
// shifts, drives the mux selects and captures the mux bank output.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned W  = ALU_W,
  parameter int unsigned SW = $clog2(W)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] opcode,
  input  logic [W-1:0]    operand_a,
  input  logic [W-1:0]    operand_b,
  input  logic [SW-1:0]   shamt,
  input  logic [W-1:0]    res_in,
  output logic [W-1:0]    a_q,
  output logic [W-1:0]    b_q,
  output logic [W-1:0]    shift_q,
  output logic            s0,
  output logic            s1,
  output logic            s2,
  output logic [W-1:0]    result,
  output logic            busy,
  output logic            done
);

  state_e          state_q;
  state_e          state_n;
  logic [OP_W-1:0] op_q;
  logic            load;
  logic            step;
  logic            capture;
  logic            arith;
  logic            last_c;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_n = state_q;
    load    = 1'b0;
    step    = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load = 1'b1;
          if (is_shift_op(opcode) && (shamt != '0)) begin
            state_n = ST_SHIFT;
          end else begin
            state_n = ST_SELECT;
          end
        end
      end
      ST_SHIFT: begin
        step = 1'b1;
        if (last_c) begin
          state_n = ST_SELECT;
        end
      end
      ST_SELECT: begin
        capture = 1'b1;
        state_n = ST_DONE;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Operand latches, result capture and registered status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (load) begin
        a_q  <= operand_a;
        b_q  <= operand_b;
        op_q <= opcode;
      end
      if (capture) begin
        result <= res_in;
      end
      busy <= (state_n != ST_IDLE);
      done <= (state_n == ST_DONE);
    end
  end

  // Shift direction follows the accepted opcode
  assign arith = is_arith_shift(op_q);

  alu_shift_reg #(
    .W  (W),
    .SW (SW)
  ) u_shift (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .arith    (arith),
    .load_val (operand_a),
    .load_cnt (shamt),
    .shift_q  (shift_q),
    .last_c   (last_c)
  );

  // Mux selects track the latched opcode and hold through IDLE
  assign s0 = op_q[0];
  assign s1 = op_q[1];
  assign s2 = op_q[2];

endmodule
